// File: rtl/mdu_alucont.sv
// mdu_alucont: ALU control decode plus a sequencer for multi-cycle multiply/divide.
//
// gout_o is a pure combinational decode of aluop_i/funct_i and does not depend on the
// sequencer state. An MDU instruction (mult/multu/div/divu) accepted in IDLE starts a
// DATA_W-step iteration sequence (RUN). A single HI/LO write cycle follows (DONE). A divide
// by zero skips RUN and goes straight to DONE with md_err_o set. While the sequencer is
// busy, any MDU or mfhi/mflo instruction is stalled. Other instructions flow freely.
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_i        asynchronous, active-high reset
//   valid_i        decode-stage instruction valid
//   aluop_i        main-control ALU op: 00 add, 01 sub, 10 R-type, 11 nori
//   funct_i        instruction function field
//   div_by_zero_i  divisor is zero; only looked at on the accept cycle of a divide
//   gout_o         4-bit ALU control (combinational)
//   md_op_o        latched MDU op: 00 mult, 01 multu, 10 div, 11 divu
//   md_start_o     accept pulse (combinational)
//   md_step_o      one MDU iteration this cycle
//   md_last_o      final MDU iteration this cycle
//   hilo_we_o      HI/LO write strobe
//   md_err_o       last accepted divide had a zero divisor
//   busy_o         sequencer not idle
//   stall_o        hold PC/decode (combinational)
module mdu_alucont #(
  parameter int unsigned DATA_W = 32
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       valid_i,
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  input  logic       div_by_zero_i,
  output logic [3:0] gout_o,
  output logic [1:0] md_op_o,
  output logic       md_start_o,
  output logic       md_step_o,
  output logic       md_last_o,
  output logic       hilo_we_o,
  output logic       md_err_o,
  output logic       busy_o,
  output logic       stall_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CntInit = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [1:0]       md_op_q;
  logic             md_err_q;
  logic             step_q;
  logic             last_q;
  logic             hilo_we_q;

  logic is_rtype;
  logic is_md;
  logic is_hl;
  logic accept;
  logic div_zero;

  // ---------------------------------------------------------------------------
  // ALU control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    gout_o = 4'b0010;
    unique case (aluop_i)
      2'b00: gout_o = 4'b0010;
      2'b01: gout_o = 4'b0110;
      2'b11: gout_o = 4'b1010;
      2'b10: begin
        case (funct_i)
          6'b100000: gout_o = 4'b0010;  // add
          6'b100010: gout_o = 4'b0110;  // sub
          6'b100100: gout_o = 4'b0000;  // and
          6'b100101: gout_o = 4'b0001;  // or
          6'b101010: gout_o = 4'b0111;  // slt
          6'b010100: gout_o = 4'b1000;  // brv
          6'b100001: gout_o = 4'b1001;  // jmxor
          default:   gout_o = 4'b0010;  // includes MDU and mfhi/mflo
        endcase
      end
      default: gout_o = 4'b0010;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Instruction class decode
  // ---------------------------------------------------------------------------
  assign is_rtype = (aluop_i == 2'b10);
  // mult/multu/div/divu are 0110xx; the low two bits are the MDU op
  assign is_md    = is_rtype && (funct_i[5:2] == 4'b0110);
  assign is_hl    = is_rtype && ((funct_i == 6'b010000) || (funct_i == 6'b010010));

  // Accept only from IDLE; an instruction arriving during reset is not taken.
  assign accept   = valid_i && is_md && (state_q == StIdle) && !reset_i;
  // funct_i[1] separates divides from multiplies
  assign div_zero = funct_i[1] && div_by_zero_i;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      count_q   <= '0;
      md_op_q   <= 2'b00;
      md_err_q  <= 1'b0;
      step_q    <= 1'b0;
      last_q    <= 1'b0;
      hilo_we_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            md_op_q  <= funct_i[1:0];
            md_err_q <= div_zero;
            count_q  <= CntInit;
            if (div_zero) begin
              // No iterations for a zero divisor: write HI/LO next cycle.
              state_q   <= StDone;
              hilo_we_q <= 1'b1;
            end else begin
              state_q <= StRun;
              step_q  <= 1'b1;
              last_q  <= 1'b0;  // CntInit is never zero since DATA_W >= 2
            end
          end
        end
        StRun: begin
          if (count_q == '0) begin
            state_q   <= StDone;
            step_q    <= 1'b0;
            last_q    <= 1'b0;
            hilo_we_q <= 1'b1;
          end else begin
            count_q <= count_q - CNT_W'(1);
            // Registered flag: next cycle is the final iteration.
            last_q  <= (count_q == CNT_W'(1));
          end
        end
        StDone: begin
          state_q   <= StIdle;
          hilo_we_q <= 1'b0;
        end
        default: begin
          state_q   <= StIdle;
          step_q    <= 1'b0;
          last_q    <= 1'b0;
          hilo_we_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign md_op_o    = md_op_q;
  assign md_err_o   = md_err_q;
  assign md_step_o  = step_q;
  assign md_last_o  = last_q;
  assign hilo_we_o  = hilo_we_q;
  assign busy_o     = (state_q != StIdle);
  assign md_start_o = accept;
  assign stall_o    = valid_i && (is_md || is_hl) && (state_q != StIdle);

endmodule

// File: doc/mdu_alucont.md
# mdu_alucont

Parametrised ALU control unit for the MIPS-lite datapath. It extends the combinational aluop/funct decode with a sequencer for multi-cycle multiply/divide. The block sits between main control and the ALU/MDU. It decodes every instruction to a 4-bit ALU control, and it runs a DATA_W-step iteration sequence for mult/multu/div/divu. While that sequence is in flight it stalls any dependent HI/LO access or second MDU operation; independent ALU instructions keep flowing.

## Interface
- DATA_W, 32, operand width; sets the number of iteration steps. Minimum 2.
- CNT_W, $clog2(DATA_W), step counter width (derived localparam, not overridable).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- valid  in  1  decode-stage instruction valid this cycle.
- aluop  in  2  from main control: 00 add, 01 sub, 10 R-type, 11 nori.
- funct  in  6  instruction function field.
- div_by_zero  in  1  divisor==0; sampled only on the accept cycle.
- gout  out  4  ALU control (combinational).
- md_op  out  2  latched MDU op: 00 mult, 01 multu, 10 div, 11 divu.
- md_start  out  1  accept pulse (combinational, Mealy).
- md_step  out  1  one iteration per cycle while RUN.
- md_last  out  1  final iteration (count==0 in RUN).
- hilo_we  out  1  HI/LO write strobe, one cycle in DONE.
- md_err  out  1  last accepted divide had a zero divisor.
- busy  out  1  state != IDLE.
- stall  out  1  hold PC/decode (combinational).

## Operation
- gout decode (pure combinational, no latch, independent of state):
  - aluop 00 → 0010.
  - aluop 01 → 0110.
  - aluop 11 → 1010.
  - aluop 10, by funct:
    - 100000 → 0010 add
    - 100010 → 0110 sub
    - 100100 → 0000 and
    - 100101 → 0001 or
    - 101010 → 0111 slt
    - 010100 → 1000 brv
    - 100001 → 1001 jmxor
    - any other funct, including MDU and mfhi/mflo → 0010.
- is_md = aluop==10 & funct ∈ {011000 mult, 011001 multu, 011010 div, 011011 divu}; md_op = funct[1:0].
- is_hl = aluop==10 & funct ∈ {010000 mfhi, 010010 mflo}.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on valid & is_md, md_start=1, md_op latched, count←DATA_W-1, md_err←(funct[1] & div_by_zero). Next state is DONE if funct[1] & div_by_zero, else RUN.
  - RUN: md_step=1 every cycle. count decrements. At count==0, md_last=1 and next state is DONE.
  - DONE: hilo_we=1 for one cycle, then IDLE.
- stall = valid & (is_md | is_hl) & (state != IDLE). A stalled instruction is re-presented by the pipeline and accepted in the first IDLE cycle.
- md_err holds until the next accept overwrites it.
- Reset values: state IDLE, count 0, md_op 00, md_err 0. busy, md_step, md_last and hilo_we are 0. md_start and stall are 0 whenever valid=0.
- Reset mid-RUN/DONE aborts the sequence immediately. No hilo_we is issued for the aborted op.

## Timing
- Accept at cycle 0.
- md_step high in cycles 1..DATA_W; md_last in cycle DATA_W.
- hilo_we in cycle DATA_W+1; IDLE again in cycle DATA_W+2.
- Divide by zero: accept c0, DONE (hilo_we) c1, md_err=1 from c1, IDLE c2.
- An MDU op presented in DONE is stalled. It is accepted the next cycle, giving no back-to-back overlap.
- Non-MDU, non-HI/LO instructions never stall. Their gout is valid in any state.
- div_by_zero is ignored outside the accept cycle and for mult/multu.

## Test plan
- Decode sweep, state IDLE:
  - aluop 00 → 0010; 01 → 0110; 11 → 1010.
  - aluop 10 with funct 100010 → 0110, 101010 → 0111, 010100 → 1000, 100001 → 1001.
  - aluop 10 with funct 111111 → 0010.
- DATA_W=32, mult accepted c0:
  - md_start=1 at c0 only.
  - md_step=1 c1–c32, md_last=1 at c32 only.
  - hilo_we=1 at c33 only; busy low at c34.
- mflo valid from c5 during that mult:
  - stall=1 c5–c33, stall=0 c34.
  - An add presented at c10 gives gout=0010, stall=0.
- divu with div_by_zero=1 at c0:
  - no md_step pulses; hilo_we=1 at c1; md_err=1 from c1.
  - A subsequent mult with div_by_zero=1 clears md_err after its accept.
- DATA_W=4:
  - div accepted c0; reset asserted c2.
  - All outputs 0 and busy=0 immediately; no hilo_we.
  - After release, a new mult runs the full 4-step sequence.
- Second mult presented during DONE: stalled one cycle, md_start the following cycle, md_op=00.
